dmem_arbiter: RTL and testbench

- Arbitrates the single-port data memory (2^ADDR_BITS x DATA_WIDTH, synchronous read) between two requesters.
- Port 0 is the CU load/store datapath (address from ALU result, data from operand1).
- Port 1 is the debug/program-loader port.
- Round-robin grant, one transaction in flight at a time, fixed 3-cycle request-to-acknowledge latency.

---
 rtl/dmem_arbiter_if.sv | 87 ++++++++
 rtl/dmem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//
// Purpose:
//    Bundles every handshake and memory-bus signal of the data-memory arbiter
//    so that the arbiter, the two requesters and the memory model share one
//    port object. Clock and reset stay outside the bundle as plain ports.
//
// Parameters:
//    DATA_WIDTH  data word width
//    ADDR_BITS   memory address width
//
// Signals (direction given from the arbiter's point of view, modport slave):
//    req0/req1         in   request strobe of port 0 (CU) / port 1 (loader)
//    w_r0/w_r1         in   direction, 1=write, 0=read
//    addr0/addr1       in   requested word address
//    wdata0/wdata1     in   write data
//    gnt0/gnt1         out  grant pulse, high during the memory access cycle
//    ack0/ack1         out  completion pulse, one cycle
//    rdata0/rdata1     out  read data, updated only by that port's read ack
//    mem_en            out  memory access strobe
//    mem_w_r           out  memory write enable, 1=write
//    mem_addr          out  memory address
//    mem_din           out  memory write data
//    mem_dout          in   memory read data, valid the cycle after mem_en
//    busy              out  arbiter is not idle
//
// Modports:
//    slave   the arbiter itself
//    master  the environment: requesters plus the memory
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 5
);

   // Port 0 (CU load/store datapath)
   logic                  req0;
   logic                  w_r0;
   logic [ADDR_BITS-1:0]  addr0;
   logic [DATA_WIDTH-1:0] wdata0;
   logic                  gnt0;
   logic                  ack0;
   logic [DATA_WIDTH-1:0] rdata0;

   // Port 1 (debug / program loader)
   logic                  req1;
   logic                  w_r1;
   logic [ADDR_BITS-1:0]  addr1;
   logic [DATA_WIDTH-1:0] wdata1;
   logic                  gnt1;
   logic                  ack1;
   logic [DATA_WIDTH-1:0] rdata1;

   // Single-port synchronous memory
   logic                  mem_en;
   logic                  mem_w_r;
   logic [ADDR_BITS-1:0]  mem_addr;
   logic [DATA_WIDTH-1:0] mem_din;
   logic [DATA_WIDTH-1:0] mem_dout;

   // Status
   logic                  busy;

   // The arbiter consumes requests and memory read data and produces the rest.
   modport slave (
      input  req0, w_r0, addr0, wdata0,
      output gnt0, ack0, rdata0,
      input  req1, w_r1, addr1, wdata1,
      output gnt1, ack1, rdata1,
      output mem_en, mem_w_r, mem_addr, mem_din,
      input  mem_dout,
      output busy
   );

   // The environment drives requests and memory read data and observes the rest.
   modport master (
      output req0, w_r0, addr0, wdata0,
      input  gnt0, ack0, rdata0,
      output req1, w_r1, addr1, wdata1,
      input  gnt1, ack1, rdata1,
      input  mem_en, mem_w_r, mem_addr, mem_din,
      output mem_dout,
      input  busy
   );

endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//    Shares a single-port, synchronous-read data memory between two
//    requesters: port 0 is the CU load/store datapath, port 1 is the
//    debug/program-loader port. Only one transaction is in flight at a time
//    and every transaction takes exactly three cycles:
//
//       edge E0 : request sampled in IDLE, command latched     -> ACCESS
//       E0..E1  : gnt[sel] and mem_en high, command on the bus
//       edge E1 : memory performs the access                   -> RESP
//       edge E2 : ack[sel] and (on a read) rdata[sel] latched  -> IDLE
//       E2..E3  : ack visible; a request seen here is taken at E3
//
//    Simultaneous requests are resolved round-robin by default.
//
// Configuration:
//    `define DMEM_ARB_FIXED_PRIO_EN  port 0 always wins simultaneous requests
//                                    and the round-robin pointer stays at 0.
//
// Ports:
//    clk     in   system clock, all state on the rising edge
//    rst     in   asynchronous active-high reset
//    bus_io  dmem_arbiter_if.slave, carrying both requester ports, the
//            memory bus and the busy flag (see dmem_arbiter_if.sv)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 5
) (
   input  logic          clk,
   input  logic          rst,
   dmem_arbiter_if.slave bus_io
);

   // One-hot so that every decoded output depends on a single flop bit plus
   // stable command registers, which keeps the combinational outputs clean.
   typedef enum logic [2:0] {
      IDLE   = 3'b001,
      ACCESS = 3'b010,
      RESP   = 3'b100
   } state_e;

   state_e                state_q;
   state_e                state_d;

   // Port that wins the next tie; flips to the other port after every access.
   logic                  rrPtr_q;
   logic                  rrPtr_d;

   // Command register: which port owns the transaction and what it asked for.
   logic                  sel_q;
   logic                  sel_d;
   logic                  cmdWr_q;
   logic                  cmdWr_d;
   logic [ADDR_BITS-1:0]  cmdAddr_q;
   logic [ADDR_BITS-1:0]  cmdAddr_d;
   logic [DATA_WIDTH-1:0] cmdData_q;
   logic [DATA_WIDTH-1:0] cmdData_d;

   // Registered completion outputs.
   logic                  ack0_q;
   logic                  ack0_d;
   logic                  ack1_q;
   logic                  ack1_d;
   logic [DATA_WIDTH-1:0] rdata0_q;
   logic [DATA_WIDTH-1:0] rdata0_d;
   logic [DATA_WIDTH-1:0] rdata1_q;
   logic [DATA_WIDTH-1:0] rdata1_d;

   // Arbitration helpers.
   logic                  anyReq;
   logic                  winner;
   logic                  inAccess;

   // Winner selection for the current IDLE cycle. A lone request wins
   // outright; a tie goes to the port named by the round-robin pointer. In
   // the fixed-priority build the pointer is pinned to 0, so the same
   // expression hands every tie to the CU port.
   assign anyReq = bus_io.req0 | bus_io.req1;

   always_comb begin
      winner = 1'b0;
      if (bus_io.req0 && bus_io.req1) begin
         winner = rrPtr_q;
      end else if (bus_io.req1) begin
         winner = 1'b1;
      end
   end

   // State and datapath register bank. The asynchronous reset drops the FSM
   // straight back to IDLE, which removes mem_en in the same instant, so a
   // write whose memory edge has not happened yet never lands, and an
   // in-flight transaction is abandoned without an ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         rrPtr_q   <= 1'b0;
         sel_q     <= 1'b0;
         cmdWr_q   <= 1'b0;
         cmdAddr_q <= '0;
         cmdData_q <= '0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         state_q   <= state_d;
         rrPtr_q   <= rrPtr_d;
         sel_q     <= sel_d;
         cmdWr_q   <= cmdWr_d;
         cmdAddr_q <= cmdAddr_d;
         cmdData_q <= cmdData_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   // Next-state logic. Everything holds by default and acks default low so
   // they pulse for exactly one cycle. Requester inputs are only looked at
   // in IDLE; once the command is latched the ports may change freely.
   always_comb begin
      state_d   = state_q;
      rrPtr_d   = rrPtr_q;
      sel_d     = sel_q;
      cmdWr_d   = cmdWr_q;
      cmdAddr_d = cmdAddr_q;
      cmdData_d = cmdData_q;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;

      case (state_q)
         IDLE: begin
            if (anyReq) begin
               sel_d     = winner;
               cmdWr_d   = winner ? bus_io.w_r1   : bus_io.w_r0;
               cmdAddr_d = winner ? bus_io.addr1  : bus_io.addr0;
               cmdData_d = winner ? bus_io.wdata1 : bus_io.wdata0;
               state_d   = ACCESS;
            end
         end

         ACCESS: begin
            state_d = RESP;
         end

         RESP: begin
            // Memory read data is valid now, one cycle after the access edge.
            // Only the owning port's read register is touched, so the other
            // port's last read result survives any number of foreign accesses.
            if (sel_q) begin
               ack1_d = 1'b1;
               if (!cmdWr_q) begin
                  rdata1_d = bus_io.mem_dout;
               end
            end else begin
               ack0_d = 1'b1;
               if (!cmdWr_q) begin
                  rdata0_d = bus_io.mem_dout;
               end
            end
`ifdef DMEM_ARB_FIXED_PRIO_EN
            rrPtr_d = 1'b0;
`else
            rrPtr_d = ~sel_q;
`endif
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Decoded outputs. Grant and the memory strobe exist only in ACCESS; the
   // bus fields are forced to zero elsewhere so the memory never sees stale
   // commands and everything reads 0 straight out of reset.
   assign inAccess        = (state_q == ACCESS);

   assign bus_io.gnt0     = inAccess & ~sel_q;
   assign bus_io.gnt1     = inAccess &  sel_q;

   assign bus_io.mem_en   = inAccess;
   assign bus_io.mem_w_r  = inAccess & cmdWr_q;
   assign bus_io.mem_addr = inAccess ? cmdAddr_q : '0;
   assign bus_io.mem_din  = inAccess ? cmdData_q : '0;

   assign bus_io.busy     = (state_q != IDLE);

   // Registered outputs.
   assign bus_io.ack0     = ack0_q;
   assign bus_io.ack1     = ack1_q;
   assign bus_io.rdata0   = rdata0_q;
   assign bus_io.rdata1   = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter. Each request pushes its expected grant and
// its expected ack into two queues; a monitor on the falling edge pops and
// compares whenever the arbiter shows a grant or an ack. A small behavioural
// memory (synchronous read) sits on the memory bus with a few words preloaded.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int DW = 8;
   localparam int AW = 5;

   typedef struct {
      bit            port;
      int            cyc;
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } gntExp_t;

   typedef struct {
      bit            port;
      int            cyc;
      logic [DW-1:0] r0;
      logic [DW-1:0] r1;
   } ackExp_t;

   logic clk = 1'b0;
   logic rst;

   dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) bus ();

   dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   gntExp_t       gntQ[$];
   ackExp_t       ackQ[$];
   int            nCompared   = 0;
   int            nMismatched = 0;
   int            cyc         = 0;
   logic [DW-1:0] expR0       = '0;
   logic [DW-1:0] expR1       = '0;
   bit            measure     = 1'b0;
   int            busyCnt     = 0;

   // Preloaded words: 1 and 2 feed the round-robin reads, 4 is the word the
   // aborted write must not overwrite.
   logic [DW-1:0] mem [0:31] = '{1: 8'h3C, 2: 8'h5A, 4: 8'h44, default: 8'h00};

   // 100 MHz-style free-running clock.
   always #5 clk = ~clk;

   // Cycle counter; stimulus and monitor both read it between edges.
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural single-port memory with a registered read port.
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_w_r) mem[bus.mem_addr] <= bus.mem_din;
         else             bus.mem_dout      <= mem[bus.mem_addr];
      end
   end

   // Busy-duty-cycle sampler, active only inside a measurement window.
   always @(negedge clk) begin
      if (measure) busyCnt <= busyCnt + int'(bus.busy);
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic driveReq(input bit port, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      if (port) begin
         bus.req1 = 1'b1; bus.w_r1 = wr; bus.addr1 = addr; bus.wdata1 = data;
      end else begin
         bus.req0 = 1'b1; bus.w_r0 = wr; bus.addr0 = addr; bus.wdata0 = data;
      end
   endtask

   task automatic dropReq(input bit port);
      if (port) bus.req1 = 1'b0;
      else      bus.req0 = 1'b0;
   endtask

   // Queue the expected grant (one cycle after the request cycle 'base') and
   // ack (three cycles after), with the rdata pair expected at that ack.
   task automatic pushExp(input bit port, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [DW-1:0] rdExp, input int base);
      gntQ.push_back('{port: port, cyc: base + 1, wr: wr, addr: addr, data: data});
      if (!wr) begin
         if (port) expR1 = rdExp;
         else      expR0 = rdExp;
      end
      ackQ.push_back('{port: port, cyc: base + 3, r0: expR0, r1: expR1});
   endtask

   // One complete transaction on one port, starting in an IDLE cycle and
   // returning in its ack cycle so the next call runs back-to-back.
   task automatic applyStimulus(input bit port, input bit wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data, input logic [DW-1:0] rdExp);
      driveReq(port, wr, addr, data);
      pushExp(port, wr, addr, data, rdExp, cyc);
      @(posedge clk); #1;
      dropReq(port);
      repeat (2) begin @(posedge clk); #1; end
   endtask

   // Scoreboard monitor: every grant and every ack must match the head of
   // its queue; one appearing with an empty queue is itself a failure.
   always @(negedge clk) begin
      gntExp_t g;
      ackExp_t a;
      if (!rst) begin
         if (bus.gnt0 || bus.gnt1) begin
            if (gntQ.size() == 0) begin
               checkOutput("gnt_unexpected", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
            end else begin
               g = gntQ.pop_front();
               checkOutput("gnt_onehot", bus.gnt0 & bus.gnt1, 0);
               checkOutput("gnt_port", bus.gnt1, g.port);
               checkOutput("gnt_cycle", cyc, g.cyc);
               checkOutput("gnt_mem_en", bus.mem_en, 1);
               checkOutput("gnt_mem_w_r", bus.mem_w_r, g.wr);
               checkOutput("gnt_mem_addr", bus.mem_addr, g.addr);
               if (g.wr) checkOutput("gnt_mem_din", bus.mem_din, g.data);
            end
         end
         if (bus.ack0 || bus.ack1) begin
            if (ackQ.size() == 0) begin
               checkOutput("ack_unexpected", {30'd0, bus.ack1, bus.ack0}, 32'd0);
            end else begin
               a = ackQ.pop_front();
               checkOutput("ack_onehot", bus.ack0 & bus.ack1, 0);
               checkOutput("ack_port", bus.ack1, a.port);
               checkOutput("ack_cycle", cyc, a.cyc);
               checkOutput("ack_rdata0", bus.rdata0, a.r0);
               checkOutput("ack_rdata1", bus.rdata1, a.r1);
               checkOutput("ack_busy", bus.busy, 0);
            end
         end
      end
   end

   // Safety net so the run always ends on its own.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence.
   initial begin
      int base;
      rst = 1'b1;
      bus.req0 = 1'b0; bus.w_r0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 1'b0; bus.w_r1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_gnt", {bus.gnt1, bus.gnt0}, 0);
      checkOutput("rst_ack", {bus.ack1, bus.ack0}, 0);
      checkOutput("rst_rdata0", bus.rdata0, 0);
      checkOutput("rst_rdata1", bus.rdata1, 0);
      checkOutput("rst_mem_en", bus.mem_en, 0);
      checkOutput("rst_mem_w_r", bus.mem_w_r, 0);
      checkOutput("rst_busy", bus.busy, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Port 1 writes 0xA5 to word 3, then reads it back.
      applyStimulus(1'b1, 1'b1, 5'd3, 8'hA5, 8'h00);
      applyStimulus(1'b1, 1'b0, 5'd3, 8'h00, 8'hA5);

      // Both ports hold read requests through four transactions.
      base = cyc;
      driveReq(1'b0, 1'b0, 5'd1, 8'h00);
      driveReq(1'b1, 1'b0, 5'd2, 8'h00);
      for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
         pushExp(1'b0, 1'b0, 5'd1, 8'h00, 8'h3C, base + 3 * k);
`else
         if (k % 2 == 0) pushExp(1'b0, 1'b0, 5'd1, 8'h00, 8'h3C, base + 3 * k);
         else            pushExp(1'b1, 1'b0, 5'd2, 8'h00, 8'h5A, base + 3 * k);
`endif
      end
      repeat (10) @(posedge clk);
      #1;
      dropReq(1'b0);
      dropReq(1'b1);
      repeat (2) begin @(posedge clk); #1; end

      // Port 0 back-to-back: two writes (including the top word) then a read.
      applyStimulus(1'b0, 1'b1, 5'd0,  8'h11, 8'h00);
      applyStimulus(1'b0, 1'b1, 5'd31, 8'h22, 8'h00);
      applyStimulus(1'b0, 1'b0, 5'd31, 8'h00, 8'h22);

      // Read isolation and busy duty cycle over two back-to-back reads.
      measure = 1'b1;
      applyStimulus(1'b0, 1'b0, 5'd0,  8'h00, 8'h11);
      applyStimulus(1'b1, 1'b0, 5'd31, 8'h00, 8'h22);
      measure = 1'b0;
      checkOutput("busy_4_of_6", busyCnt, 4);

      // Port 0 read leaves the pointer favouring port 1 before the reset.
      applyStimulus(1'b0, 1'b0, 5'd4, 8'h00, 8'h44);

      // Reset in the ACCESS cycle of a port 0 write of 0xFF to word 4.
      driveReq(1'b0, 1'b1, 5'd4, 8'hFF);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checkOutput("midrst_mem_en", bus.mem_en, 0);
      checkOutput("midrst_gnt0", bus.gnt0, 0);
      checkOutput("midrst_busy", bus.busy, 0);
      dropReq(1'b0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("midrst_ack", {bus.ack1, bus.ack0}, 0);
      checkOutput("midrst_rdata0", bus.rdata0, 0);
      checkOutput("midrst_rdata1", bus.rdata1, 0);
      expR0 = '0;
      expR1 = '0;
      rst = 1'b0;
      @(posedge clk); #1;

      // Tie right after reset must go to port 0; port 1 then reads word 4,
      // which must still hold its pre-reset value.
      base = cyc;
      driveReq(1'b0, 1'b0, 5'd1, 8'h00);
      driveReq(1'b1, 1'b0, 5'd4, 8'h00);
      pushExp(1'b0, 1'b0, 5'd1, 8'h00, 8'h3C, base);
      pushExp(1'b1, 1'b0, 5'd4, 8'h00, 8'h44, base + 3);
      @(posedge clk); #1;
      dropReq(1'b0);
      repeat (3) begin @(posedge clk); #1; end
      dropReq(1'b1);
      repeat (2) begin @(posedge clk); #1; end

      // Every queued grant and ack must have been seen.
      repeat (4) @(posedge clk);
      #1;
      checkOutput("gnt_queue_drained", gntQ.size(), 0);
      checkOutput("ack_queue_drained", ackQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
